ram_bist_ctrl: RTL and testbench
================================

Name: ram_bist_ctrl

Overview:
- Initiator that drives the 64-word synchronous data RAM through its Mem_Addr/Mem_Write/Mem_Read port.
- It writes an address-derived pattern to every word, then reads every word back and compares it with the pattern.
- It reports pass/fail and the first failing address, and drives the board LEDs with a byte of the last word it compared, selected by MUX.
- It sits between the board switches/buttons and the RAM.

Parameters:
- ADDR_W, 6, RAM address width; the test covers 2^ADDR_W words.
- DATA_W, 32, RAM word width; must be a multiple of 8 and ≥ 32.
- SEED, 32'h1357_9BDF, pattern base.
- STEP, 32'h0000_0101, pattern increment per address.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level sampled each edge; begins a run from IDLE or DONE.
- MUX  in  2  LED byte select.
- Mem_Addr  out  ADDR_W  RAM address.
- Mem_Write  out  1  RAM write enable.
- Mem_Read  out  1  RAM read enable.
- M_W_Data  out  DATA_W  RAM write data.
- M_R_Data  in  DATA_W  RAM read data; registered in the RAM, valid the cycle after the read edge.
- busy  out  1  run in progress.
- done  out  1  run finished.
- pass  out  1  valid when done=1.
- err_addr  out  ADDR_W  first mismatching address; valid when done=1 and pass=0.
- LED  out  8  selected byte of the captured word.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0) forces, immediately and asynchronously: state IDLE; Mem_Addr=0, Mem_Write=0, Mem_Read=0, M_W_Data=0, busy=0, done=0, pass=0, err_addr=0, captured word=0, LED=0. Reset mid-run aborts the run with no completion flag.
- Pattern: P(a) = (SEED + a*STEP) truncated/zero-extended to DATA_W.
- States:
  - IDLE: waits for start.
  - WR: writes one word per cycle.
  - RD: issues one read per cycle.
  - DRAIN: final compare.
  - DONE: result held.
- Timing, with the edge that samples start=1 called E0:
  - E0: state WR. Mem_Write=1, Mem_Addr=0, M_W_Data=P(0); busy=1; done, pass, err_addr cleared.
  - E1..E64: the RAM writes address k-1 at edge Ek; the controller advances the address and data each edge.
  - After E64: Mem_Write=0, Mem_Read=1, Mem_Addr=0, state RD.
  - E65..E128: the RAM reads address k-65 at edge Ek. From E66 onward, each edge compares M_R_Data with P(address issued the previous edge) and loads that M_R_Data into the captured word.
  - After E128: Mem_Read=0, state DRAIN.
  - E129: last compare; state DONE; done=1, pass=1, busy=0.
  - A full pass therefore completes 129 cycles after E0.
- Mismatch at the compare for address a (edge E66+a):
  - Go to DONE at that edge: done=1, pass=0, err_addr=a, busy=0, Mem_Read=0.
  - The captured word holds the bad data.
  - Remaining addresses are not read.
- Mem_Write and Mem_Read are never both 1. Both are 0 in IDLE and DONE.
- Mem_Addr wraps from 2^ADDR_W-1 to 0 at the phase change; no out-of-range address is ever driven.
- start while busy=1 is ignored.
- start in DONE starts a new run exactly as from IDLE. done, pass and err_addr clear at E0; the captured word keeps its value until the first new compare.
- start held high continuously restarts one cycle after each DONE.
- LED = captured word byte MUX, where MUX=0 is bits 7:0 and MUX=3 is bits 31:24. LED updates combinationally-from-register, i.e. within the cycle MUX changes.

Test Plan:
- Fault-free behavioural RAM, pulse start → busy=1 for 129 cycles; exactly 64 write and 64 read cycles; then done=1, pass=1; captured word=P(63)=32'h1357_DB1E; LED with MUX=0 → 8'h1E, MUX=3 → 8'h13.
- RAM model forcing bit 0 to 1 on reads of address 5 → done at E71, pass=0, err_addr=6'd5, captured word=32'h1357_A0E5, LED with MUX=0 → 8'hE5; Mem_Read=0 from E71.
- Pulse start again at cycle E10 of a run → no restart; done still rises at E129.
- Assert rst_n=0 during WR at E30 → Mem_Write drops before the next edge; all outputs 0; after release, state IDLE with no writes until start.
- After a fail, clear the fault and pulse start → done/pass/err_addr clear at E0; pass=1 after 129 cycles.
- Every cycle of all runs: assert !(Mem_Write && Mem_Read) and Mem_Addr < 64.

Source files
------------

// File: rtl/ram_bist_ctrl.sv
// ============================================================================
// ram_bist_ctrl : write/read-back march over the 64-word data RAM with
//                 pass/fail, first-error address and LED byte readout.
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ram_bist_ctrl #(
    parameter int          ADDR_W = 6,
    parameter int          DATA_W = 32,
    parameter logic [31:0] SEED   = 32'h1357_9BDF,
    parameter logic [31:0] STEP   = 32'h0000_0101
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        MUX,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic              Mem_Write,
    output logic              Mem_Read,
    output logic [DATA_W-1:0] M_W_Data,
    input  logic [DATA_W-1:0] M_R_Data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] err_addr,
    output logic [7:0]        LED
);

    localparam logic [DATA_W-1:0] c_PAT0     = DATA_W'(SEED);
    localparam logic [DATA_W-1:0] c_PAT_STEP = DATA_W'(STEP);
    localparam logic [ADDR_W-1:0] c_ADDR_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_RD    = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                wr_q;
    logic                rd_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   exp_q;
    logic [ADDR_W-1:0]   cmp_addr_q;
    logic                cmp_vld_q;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;
    logic [ADDR_W-1:0]   err_addr_q;
    logic [DATA_W-1:0]   cap_q;

    logic                w_cmp_ok;
    logic [7:0]          w_led;

    // Read data lags the issued address by one edge; exp_q/cmp_addr_q track that lag.
    assign w_cmp_ok = (M_R_Data == exp_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            wdata_q    <= '0;
            exp_q      <= '0;
            cmp_addr_q <= '0;
            cmp_vld_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_addr_q <= '0;
            cap_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q    <= ST_WR;
                        wr_q       <= 1'b1;
                        rd_q       <= 1'b0;
                        addr_q     <= '0;
                        wdata_q    <= c_PAT0;
                        cmp_vld_q  <= 1'b0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                        err_addr_q <= '0;
                    end
                end

                ST_WR: begin
                    if (addr_q == c_ADDR_MAX) begin
                        state_q   <= ST_RD;
                        wr_q      <= 1'b0;
                        rd_q      <= 1'b1;
                        addr_q    <= '0;
                        exp_q     <= c_PAT0;
                        cmp_vld_q <= 1'b0;
                    end else begin
                        addr_q  <= addr_q + 1'b1;
                        wdata_q <= wdata_q + c_PAT_STEP;
                    end
                end

                ST_RD: begin
                    if (cmp_vld_q && !w_cmp_ok) begin
                        state_q    <= ST_DONE;
                        rd_q       <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        pass_q     <= 1'b0;
                        err_addr_q <= cmp_addr_q;
                        cap_q      <= M_R_Data;
                    end else begin
                        if (cmp_vld_q) begin
                            cap_q <= M_R_Data;
                            exp_q <= exp_q + c_PAT_STEP;
                        end
                        cmp_vld_q  <= 1'b1;
                        cmp_addr_q <= addr_q;
                        if (addr_q == c_ADDR_MAX) begin
                            state_q <= ST_DRAIN;
                            rd_q    <= 1'b0;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                end

                ST_DRAIN: begin
                    state_q <= ST_DONE;
                    cap_q   <= M_R_Data;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    pass_q  <= w_cmp_ok;
                    if (!w_cmp_ok) begin
                        err_addr_q <= cmp_addr_q;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    wr_q    <= 1'b0;
                    rd_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_led = cap_q[7:0];
        case (MUX)
            2'd0: w_led = cap_q[7:0];
            2'd1: w_led = cap_q[15:8];
            2'd2: w_led = cap_q[23:16];
            2'd3: w_led = cap_q[31:24];
            default: w_led = cap_q[7:0];
        endcase
    end

    assign Mem_Addr  = addr_q;
    assign Mem_Write = wr_q;
    assign Mem_Read  = rd_q;
    assign M_W_Data  = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_addr  = err_addr_q;
    assign LED       = w_led;

endmodule

`default_nettype wire

// File: tb/tb_ram_bist_ctrl.sv
// ============================================================================
// tb_ram_bist_ctrl : directed self-checking bench for ram_bist_ctrl.
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ram_bist_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  MUX = 2'd0;
    logic [5:0]  Mem_Addr;
    logic        Mem_Write;
    logic        Mem_Read;
    logic [31:0] M_W_Data;
    logic [31:0] M_R_Data;
    logic        busy;
    logic        done;
    logic        pass;
    logic [5:0]  err_addr;
    logic [7:0]  LED;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [64];
    logic        fault_en = 1'b0;
    logic [31:0] r_rdata = '0;

    always #5 clk = ~clk;

    ram_bist_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .MUX       (MUX),
        .Mem_Addr  (Mem_Addr),
        .Mem_Write (Mem_Write),
        .Mem_Read  (Mem_Read),
        .M_W_Data  (M_W_Data),
        .M_R_Data  (M_R_Data),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_addr  (err_addr),
        .LED       (LED)
    );

    // Behavioural synchronous RAM; optional stuck-at-1 on bit 0 of address 5 reads.
    always @(posedge clk) begin
        if (Mem_Write) mem[Mem_Addr] <= M_W_Data;
        if (Mem_Read)  r_rdata <= mem[Mem_Addr] | ((fault_en && Mem_Addr == 6'd5) ? 32'd1 : 32'd0);
    end
    assign M_R_Data = r_rdata;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check_value("mutex", 64'(Mem_Write & Mem_Read), 64'd0);
            check_value("addr_rng", 64'(Mem_Addr < 7'd64), 64'd1);
            if (Mem_Write)
                check_value("wdata", 64'(M_W_Data), 64'(32'h1357_9BDF + 32'(Mem_Addr) * 32'h0000_0101));
        end
    end

    // Start a run (E0 is the first edge with start=1), return the edge index where done rises.
    task automatic run(input int pulse_at, output int edge_n, output int wr_n, output int rd_n,
                       output int busy_n, output logic [63:0] e0_flags);
        edge_n = -1; wr_n = 0; rd_n = 0; busy_n = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e0_flags = {40'd0, LED, 2'd0, err_addr, 6'd0, pass, done};
        wr_n += int'(Mem_Write); rd_n += int'(Mem_Read); busy_n += int'(busy);
        for (int k = 1; k <= 300; k++) begin
            if (k == pulse_at) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            wr_n += int'(Mem_Write); rd_n += int'(Mem_Read); busy_n += int'(busy);
            if (done) begin
                edge_n = k;
                break;
            end
        end
        if (edge_n < 0) check_value("run_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_led(input string tag, input logic [31:0] word);
        logic [31:0] w;
        w = word;
        for (int m = 0; m < 4; m++) begin
            MUX = 2'(m);
            #1;
            check_value(tag, 64'(LED), 64'(w[8*m +: 8]));
        end
        MUX = 2'd0;
    endtask

    initial begin
        int e, wn, rn, bn;
        logic [63:0] f0;
        for (int i = 0; i < 64; i++) mem[i] = '0;

        // Reset state
        #1;
        check_value("rst_addr",  64'(Mem_Addr), 64'd0);
        check_value("rst_wr",    64'(Mem_Write), 64'd0);
        check_value("rst_rd",    64'(Mem_Read), 64'd0);
        check_value("rst_wdata", 64'(M_W_Data), 64'd0);
        check_value("rst_busy",  64'(busy), 64'd0);
        check_value("rst_done",  64'(done), 64'd0);
        check_value("rst_pass",  64'(pass), 64'd0);
        check_value("rst_err",   64'(err_addr), 64'd0);
        check_value("rst_led",   64'(LED), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fault-free run
        run(0, e, wn, rn, bn, f0);
        check_value("p1_e0_busy", 64'(bn > 0), 64'd1);
        check_value("p1_done_edge", 64'(e), 64'd129);
        check_value("p1_busy_cyc", 64'(bn), 64'd129);
        check_value("p1_writes", 64'(wn), 64'd64);
        check_value("p1_reads", 64'(rn), 64'd64);
        check_value("p1_pass", 64'(pass), 64'd1);
        check_value("p1_busy_end", 64'(busy), 64'd0);
        check_led("p1_led", 32'h1357_DB1E);

        // Stuck bit on address 5
        fault_en = 1'b1;
        run(0, e, wn, rn, bn, f0);
        check_value("f_done_edge", 64'(e), 64'd71);
        check_value("f_pass", 64'(pass), 64'd0);
        check_value("f_err_addr", 64'(err_addr), 64'd5);
        check_value("f_rd_low", 64'(Mem_Read), 64'd0);
        check_value("f_reads", 64'(rn), 64'd7);
        check_led("f_led", 32'h1357_A0E5);
        repeat (3) @(negedge clk);
        check_value("f_hold_done", 64'(done), 64'd1);
        check_value("f_hold_rd", 64'(Mem_Read), 64'd0);

        // Recovery run after the fault is cleared
        fault_en = 1'b0;
        run(0, e, wn, rn, bn, f0);
        check_value("r_e0_done", f0[0], 64'd0);
        check_value("r_e0_pass", f0[1], 64'd0);
        check_value("r_e0_err",  64'(f0[13:8]), 64'd0);
        check_value("r_e0_led",  64'(f0[23:16]), 64'hE5);
        check_value("r_done_edge", 64'(e), 64'd129);
        check_value("r_pass", 64'(pass), 64'd1);
        check_value("r_err", 64'(err_addr), 64'd0);

        // start pulse mid-run is ignored
        run(10, e, wn, rn, bn, f0);
        check_value("ig_done_edge", 64'(e), 64'd129);
        check_value("ig_busy_cyc", 64'(bn), 64'd129);
        check_value("ig_writes", 64'(wn), 64'd64);
        check_value("ig_pass", 64'(pass), 64'd1);

        // Asynchronous reset during the write phase
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #3;
        check_value("ar_pre_wr", 64'(Mem_Write), 64'd1);
        rst_n = 1'b0;
        #1;
        check_value("ar_wr",   64'(Mem_Write), 64'd0);
        check_value("ar_addr", 64'(Mem_Addr), 64'd0);
        check_value("ar_busy", 64'(busy), 64'd0);
        check_value("ar_done", 64'(done), 64'd0);
        check_value("ar_pass", 64'(pass), 64'd0);
        check_value("ar_wdata", 64'(M_W_Data), 64'd0);
        check_value("ar_led",  64'(LED), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wn = 0; bn = 0;
        repeat (6) begin
            @(posedge clk); #1;
            wn += int'(Mem_Write); bn += int'(busy) + int'(done);
        end
        check_value("ar_idle_wr", 64'(wn), 64'd0);
        check_value("ar_idle_busy", 64'(bn), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
